// File: rtl/lsu_data_port.sv
// lsu_data_port: RV32 load/store data port between execute and a word-addressed, byte-masked memory.
// Latency: 2 cycles from request handshake to response (3 if the access is split, 1 for an error).
// Backpressure: req_ready_o is high only in IDLE. The response is held until rsp_ready_i.
// Optional feature: define LSU_MISALIGNED_EN to support misaligned accesses.
//   Word-crossing accesses then use two memory cycles.
//   Without it, any address that is not a multiple of the size returns rsp_err_o.
// Ports:
//   clk_i, rst_i                      clock, async active-high reset
//   req_valid_i/req_ready_o           request handshake
//   req_we_i, req_funct3_i            store/load select and RV32 width/sign code
//   req_addr_i, req_wdata_i           byte address and right-justified store data
//   rsp_valid_o/rsp_ready_i           response handshake
//   rsp_rdata_o, rsp_err_o            load result and fault flag
//   mem_cs_o, mem_we_o, mem_mask_o    memory chip select, write enable and byte mask
//   mem_addr_o, mem_wdata_o           memory word address and lane-aligned write data
//   mem_rdata_i                       combinational read data for mem_addr_o
module lsu_data_port #(
  parameter int DW    = 32,
  parameter int ADDRW = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic             req_we_i,
  input  logic [2:0]       req_funct3_i,
  input  logic [31:0]      req_addr_i,
  input  logic [DW-1:0]    req_wdata_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic [DW-1:0]    rsp_rdata_o,
  output logic             rsp_err_o,
  output logic             mem_we_o,
  output logic             mem_cs_o,
  output logic [3:0]       mem_mask_o,
  output logic [ADDRW-1:0] mem_addr_o,
  output logic [DW-1:0]    mem_wdata_o,
  input  logic [DW-1:0]    mem_rdata_i
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ACC0 = 2'd1;
  localparam logic [1:0] S_ACC1 = 2'd2;
  localparam logic [1:0] S_RESP = 2'd3;

  logic [1:0]       state;
  logic             we_q;
  logic [2:0]       funct3_q;
  logic [ADDRW+1:0] addr_q;
  logic [31:0]      wdata_q;
  logic             err_q;
  logic [31:0]      lo_q;    // word read in ACC0
  logic [31:0]      hi_q;    // following word read in ACC1

  // Upper address bits lie outside the memory and are ignored.
  logic unused_addr;
  assign unused_addr = ^req_addr_i[31:ADDRW+2];

  // Request decode, evaluated in IDLE
  logic f3_bad;
  logic misal;
  logic req_err;

  always_comb begin
    if (req_we_i) begin
      f3_bad = req_funct3_i[2] | (req_funct3_i[1:0] == 2'b11);
    end else begin
      f3_bad = (req_funct3_i == 3'b011) | (req_funct3_i[2:1] == 2'b11);
    end
    misal = ((req_funct3_i[1:0] == 2'b01) & req_addr_i[0]) |
            ((req_funct3_i[1:0] == 2'b10) & (req_addr_i[1:0] != 2'b00));
`ifdef LSU_MISALIGNED_EN
    req_err = f3_bad;
`else
    req_err = f3_bad | misal;
`endif
  end

  // Lane alignment of the captured request
  logic [1:0]       off;
  logic [ADDRW-1:0] word;
  logic [3:0]       size_mask;
  logic [7:0]       mask_wide;   // [3:0] first word, [7:4] spill into next word
  logic [63:0]      wdata_wide;
  logic [31:0]      raw;
  logic [31:0]      load_val;
  logic             split;

  assign off  = addr_q[1:0];
  assign word = addr_q[ADDRW+1:2];

  always_comb begin
    case (funct3_q[1:0])
      2'b00:   size_mask = 4'b0001;
      2'b01:   size_mask = 4'b0011;
      default: size_mask = 4'b1111;
    endcase
  end

  assign mask_wide  = {4'b0000, size_mask} << off;
  assign wdata_wide = {32'b0, wdata_q} << {off, 3'b000};
  // Bytes above the access size may be stale, but extension discards them.
  assign raw        = 32'({hi_q, lo_q} >> {off, 3'b000});

`ifdef LSU_MISALIGNED_EN
  assign split = (mask_wide[7:4] != 4'b0000);
`else
  assign split = 1'b0;
`endif

  always_comb begin
    case (funct3_q)
      3'b000:  load_val = {{24{raw[7]}}, raw[7:0]};
      3'b001:  load_val = {{16{raw[15]}}, raw[15:0]};
      3'b100:  load_val = {24'b0, raw[7:0]};
      3'b101:  load_val = {16'b0, raw[15:0]};
      default: load_val = raw;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state    <= S_IDLE;
      we_q     <= 1'b0;
      funct3_q <= 3'b000;
      addr_q   <= '0;
      wdata_q  <= 32'b0;
      err_q    <= 1'b0;
      lo_q     <= 32'b0;
      hi_q     <= 32'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid_i) begin
            we_q     <= req_we_i;
            funct3_q <= req_funct3_i;
            addr_q   <= req_addr_i[ADDRW+1:0];
            wdata_q  <= req_wdata_i;
            err_q    <= req_err;
            state    <= req_err ? S_RESP : S_ACC0;
          end
        end
        S_ACC0: begin
          lo_q  <= mem_rdata_i;
          state <= split ? S_ACC1 : S_RESP;
        end
        S_ACC1: begin
          hi_q  <= mem_rdata_i;
          state <= S_RESP;
        end
        default: begin
          if (rsp_ready_i) state <= S_IDLE;
        end
      endcase
    end
  end

  assign req_ready_o = (state == S_IDLE);

  always_comb begin
    mem_cs_o    = 1'b0;
    mem_we_o    = 1'b0;
    mem_mask_o  = 4'b0000;
    mem_addr_o  = '0;
    mem_wdata_o = 32'b0;
    rsp_valid_o = 1'b0;
    rsp_err_o   = 1'b0;
    rsp_rdata_o = 32'b0;
    case (state)
      S_ACC0: begin
        mem_cs_o    = 1'b1;
        mem_we_o    = we_q;
        mem_mask_o  = mask_wide[3:0];
        mem_addr_o  = word;
        mem_wdata_o = wdata_wide[31:0];
      end
      S_ACC1: begin
        // The last word wraps to word 0.
        mem_cs_o    = 1'b1;
        mem_we_o    = we_q;
        mem_mask_o  = mask_wide[7:4];
        mem_addr_o  = word + {{(ADDRW-1){1'b0}}, 1'b1};
        mem_wdata_o = wdata_wide[63:32];
      end
      S_RESP: begin
        rsp_valid_o = 1'b1;
        rsp_err_o   = err_q;
        rsp_rdata_o = (we_q | err_q) ? 32'b0 : load_val;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_lsu_data_port.sv
// tb_lsu_data_port: directed bench for lsu_data_port with a byte-masked memory model.
// Expected responses are queued at issue and compared when rsp_valid_o appears.
// Memory-side cycles are recorded per request and checked against hand-derived values.
module tb_lsu_data_port;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        mem_we;
  logic        mem_cs;
  logic [3:0]  mem_mask;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  lsu_data_port #(.DW(32), .ADDRW(8)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .req_we_i     (req_we),
    .req_funct3_i (req_funct3),
    .req_addr_i   (req_addr),
    .req_wdata_i  (req_wdata),
    .rsp_valid_o  (rsp_valid),
    .rsp_ready_i  (rsp_ready),
    .rsp_rdata_o  (rsp_rdata),
    .rsp_err_o    (rsp_err),
    .mem_we_o     (mem_we),
    .mem_cs_o     (mem_cs),
    .mem_mask_o   (mem_mask),
    .mem_addr_o   (mem_addr),
    .mem_wdata_o  (mem_wdata),
    .mem_rdata_i  (mem_rdata)
  );

  always #5 clk = ~clk;

  // Memory: combinational read, byte-masked write on the clock edge
  logic [31:0] mem [256];
  assign mem_rdata = mem[mem_addr];
  always @(posedge clk) begin
    if (mem_cs && mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (mem_mask[b]) mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
      end
    end
  end

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;
  exp_t sb[$];

  int vectors = 0;
  int errs    = 0;

  int          ncs;
  int          lat;
  logic [7:0]  acc_addr  [2];
  logic [3:0]  acc_mask  [2];
  logic [31:0] acc_wdata [2];
  logic        acc_we    [2];

`ifdef LSU_MISALIGNED_EN
  localparam logic [31:0] WORD4 = 32'h80ADBE11;
`else
  localparam logic [31:0] WORD4 = 32'h80ADBEEF;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one request, record memory cycles, check the response against the scoreboard.
  // 'hold' keeps rsp_ready low for that many extra cycles once the response is up.
  task automatic do_req(input string tag, input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] exp_rd, input logic exp_err,
                        input int exp_lat, input int hold);
    exp_t e;
    e.rdata = exp_rd;
    e.err   = exp_err;
    sb.push_back(e);
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wd;
    @(posedge clk); #1;
    req_valid = 1'b0;
    ncs = 0;
    lat = 1;
    while (!rsp_valid && lat < 12) begin
      if (mem_cs && ncs < 2) begin
        acc_addr[ncs]  = mem_addr;
        acc_mask[ncs]  = mem_mask;
        acc_wdata[ncs] = mem_wdata;
        acc_we[ncs]    = mem_we;
        ncs++;
      end
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, " latency"}, 32'(lat), 32'(exp_lat));
    e = sb.pop_front();
    if (rsp_valid) begin
      chk({tag, " rdata"}, rsp_rdata, e.rdata);
      chk({tag, " err"}, 32'(rsp_err), 32'(e.err));
      chk({tag, " req_ready in RESP"}, 32'(req_ready), 32'd0);
      for (int i = 0; i < hold; i++) begin
        @(posedge clk); #1;
        chk({tag, " hold valid"}, 32'(rsp_valid), 32'd1);
        chk({tag, " hold rdata"}, rsp_rdata, e.rdata);
        chk({tag, " hold err"}, 32'(rsp_err), 32'(e.err));
        chk({tag, " hold req_ready"}, 32'(req_ready), 32'd0);
        chk({tag, " hold cs"}, 32'(mem_cs), 32'd0);
      end
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      chk({tag, " back to idle"}, 32'(req_ready), 32'd1);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, " req_ready"}, 32'(req_ready), 32'd1);
    chk({tag, " rsp_valid"}, 32'(rsp_valid), 32'd0);
    chk({tag, " rsp_rdata"}, rsp_rdata, 32'd0);
    chk({tag, " rsp_err"}, 32'(rsp_err), 32'd0);
    chk({tag, " mem_cs"}, 32'(mem_cs), 32'd0);
    chk({tag, " mem_we"}, 32'(mem_we), 32'd0);
    chk({tag, " mem_mask"}, 32'(mem_mask), 32'd0);
    chk({tag, " mem_addr"}, 32'(mem_addr), 32'd0);
    chk({tag, " mem_wdata"}, mem_wdata, 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    chk_idle_outputs("reset");
    @(negedge clk);
    rst = 1'b0;

    // Aligned word store and load
    do_req("SW 0x10", 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 2, 0);
    chk("SW 0x10 ncs", 32'(ncs), 32'd1);
    chk("SW 0x10 we", 32'(acc_we[0]), 32'd1);
    chk("SW 0x10 mask", 32'(acc_mask[0]), 32'hF);
    chk("SW 0x10 addr", 32'(acc_addr[0]), 32'd4);
    chk("SW 0x10 wdata", acc_wdata[0], 32'hDEADBEEF);
    do_req("LW 0x10", 1'b0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 2, 0);
    chk("LW 0x10 we", 32'(acc_we[0]), 32'd0);

    // Byte store into lane 3, signed and unsigned reload
    do_req("SB 0x13", 1'b1, 3'b000, 32'h13, 32'h80, 32'h0, 1'b0, 2, 0);
    chk("SB 0x13 mask", 32'(acc_mask[0]), 32'h8);
    chk("SB 0x13 wdata", acc_wdata[0], 32'h80000000);
    do_req("LB 0x13", 1'b0, 3'b000, 32'h13, 32'h0, 32'hFFFFFF80, 1'b0, 2, 0);
    do_req("LBU 0x13", 1'b0, 3'b100, 32'h13, 32'h0, 32'h00000080, 1'b0, 2, 0);

    // Halfword in upper lanes
    do_req("SH 0x22", 1'b1, 3'b001, 32'h22, 32'hA5A5, 32'h0, 1'b0, 2, 0);
    chk("SH 0x22 mask", 32'(acc_mask[0]), 32'hC);
    chk("SH 0x22 addr", 32'(acc_addr[0]), 32'd8);
    chk("SH 0x22 wdata", acc_wdata[0], 32'hA5A50000);
    do_req("LHU 0x22", 1'b0, 3'b101, 32'h22, 32'h0, 32'h0000A5A5, 1'b0, 2, 0);
    do_req("SH2 0x22", 1'b1, 3'b001, 32'h22, 32'h8001, 32'h0, 1'b0, 2, 0);
    do_req("LH 0x22", 1'b0, 3'b001, 32'h22, 32'h0, 32'hFFFF8001, 1'b0, 2, 0);

    // Illegal funct3 codes: error response, no memory cycle
    do_req("LD f3=011", 1'b0, 3'b011, 32'h10, 32'h0, 32'h0, 1'b1, 1, 0);
    chk("LD f3=011 ncs", 32'(ncs), 32'd0);
    do_req("LD f3=110", 1'b0, 3'b110, 32'h10, 32'h0, 32'h0, 1'b1, 1, 0);
    do_req("ST f3=100", 1'b1, 3'b100, 32'h10, 32'h12345678, 32'h0, 1'b1, 1, 0);
    chk("ST f3=100 ncs", 32'(ncs), 32'd0);

`ifdef LSU_MISALIGNED_EN
    do_req("SW 0x0D", 1'b1, 3'b010, 32'h0D, 32'h11223344, 32'h0, 1'b0, 3, 0);
    chk("SW 0x0D ncs", 32'(ncs), 32'd2);
    chk("SW 0x0D acc0 addr", 32'(acc_addr[0]), 32'd3);
    chk("SW 0x0D acc0 mask", 32'(acc_mask[0]), 32'hE);
    chk("SW 0x0D acc0 wdata", acc_wdata[0], 32'h22334400);
    chk("SW 0x0D acc1 addr", 32'(acc_addr[1]), 32'd4);
    chk("SW 0x0D acc1 mask", 32'(acc_mask[1]), 32'h1);
    chk("SW 0x0D acc1 wdata", acc_wdata[1], 32'h00000011);
    do_req("LW 0x0D", 1'b0, 3'b010, 32'h0D, 32'h0, 32'h11223344, 1'b0, 3, 0);
    do_req("SH 0x41", 1'b1, 3'b001, 32'h41, 32'hBEEF, 32'h0, 1'b0, 2, 0);
    chk("SH 0x41 ncs", 32'(ncs), 32'd1);
    chk("SH 0x41 mask", 32'(acc_mask[0]), 32'h6);
    chk("SH 0x41 wdata", acc_wdata[0], 32'h00BEEF00);
    do_req("LHU 0x41", 1'b0, 3'b101, 32'h41, 32'h0, 32'h0000BEEF, 1'b0, 2, 0);
    do_req("SB 0x3FF", 1'b1, 3'b000, 32'h3FF, 32'h44, 32'h0, 1'b0, 2, 0);
    do_req("SW 0x000", 1'b1, 3'b010, 32'h0, 32'hAABBCCDD, 32'h0, 1'b0, 2, 0);
    do_req("LW 0x3FF", 1'b0, 3'b010, 32'h3FF, 32'h0, 32'hBBCCDD44, 1'b0, 3, 0);
    chk("LW 0x3FF acc0 addr", 32'(acc_addr[0]), 32'd255);
    chk("LW 0x3FF acc1 addr", 32'(acc_addr[1]), 32'd0);
    chk("LW 0x3FF acc1 mask", 32'(acc_mask[1]), 32'h7);
`else
    do_req("LW 0x0D", 1'b0, 3'b010, 32'h0D, 32'h0, 32'h0, 1'b1, 1, 0);
    chk("LW 0x0D ncs", 32'(ncs), 32'd0);
    do_req("SW 0x0D", 1'b1, 3'b010, 32'h0D, 32'h11223344, 32'h0, 1'b1, 1, 0);
    chk("SW 0x0D ncs", 32'(ncs), 32'd0);
    do_req("LH 0x41", 1'b0, 3'b001, 32'h41, 32'h0, 32'h0, 1'b1, 1, 0);
    do_req("LW 0x3FF", 1'b0, 3'b010, 32'h3FF, 32'h0, 32'h0, 1'b1, 1, 0);
    chk("LW 0x3FF ncs", 32'(ncs), 32'd0);
`endif

    // Response held under backpressure for 5 cycles
    do_req("LW stall", 1'b0, 3'b010, 32'h10, 32'h0, WORD4, 1'b0, 2, 5);

    // Reset during ACC0 of a load aborts to idle immediately
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = 1'b0;
    req_funct3 = 3'b010;
    req_addr   = 32'h10;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("pre-reset cs", 32'(mem_cs), 32'd1);
    rst = 1'b1;
    #1;
    chk_idle_outputs("mid reset");
    @(negedge clk);
    rst = 1'b0;
    do_req("LBU after reset", 1'b0, 3'b100, 32'h13, 32'h0, 32'h00000080, 1'b0, 2, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule

// File: doc/lsu_data_port.md
# lsu_data_port

Load/store unit sitting between the execute stage and the word-addressed, byte-masked data memory. It accepts one byte-addressed RV32 load or store per transaction, generates the word address, the byte mask and the lane-aligned write data, and drives the memory's `we`/`cs`. For loads it extracts, sign- or zero-extends and returns the result through a valid/ready response channel. Accesses that straddle a word boundary are split into two memory cycles when the misaligned feature is compiled in.

## Interface
- `DW`, 32: data width; only 32 supported.
- `ADDRW`, 8: memory word-address width (1 KB memory = 256 words).
- `clk_i` in 1: clock.
- `rst_i` in 1: reset, asynchronous, active-high.
- `req_valid_i` in 1: request valid.
- `req_ready_o` out 1: request accepted when high with `req_valid_i`.
- `req_we_i` in 1: 1 = store, 0 = load.
- `req_funct3_i` in 3: 000 B, 001 H, 010 W, 100 BU, 101 HU (loads); 000/001/010 (stores).
- `req_addr_i` in 32: byte address; bits [ADDRW+1:0] used, upper bits ignored.
- `req_wdata_i` in 32: store data, right-justified.
- `rsp_valid_o` out 1: response valid.
- `rsp_ready_i` in 1: response consumed.
- `rsp_rdata_o` out 32: load result; 0 for stores and errors.
- `rsp_err_o` out 1: access faulted, no memory write occurred.
- `mem_we_o` out 1, `mem_cs_o` out 1, `mem_mask_o` out 4, `mem_addr_o` out ADDRW, `mem_wdata_o` out 32: memory side.
- `mem_rdata_i` in 32: combinational read data for `mem_addr_o`.

## Operation
- FSM: IDLE, ACC0, ACC1, RESP. Reset state IDLE.
- IDLE: `req_ready_o`=1. On handshake, capture request; go ACC0. If `funct3` is invalid (011, 110, 111, or ≥011 for stores), or access is misaligned with feature off, go directly to RESP with err=1.
- ACC0: `mem_cs_o`=1, `mem_we_o`=store, `mem_addr_o`=addr[ADDRW+1:2], `off`=addr[1:0]. The mask covers bytes `off`..min(off+size-1,3): B → 1<<off; H → 0011<<off, clipped; W → 1111<<off, clipped. `mem_wdata_o` = wdata << 8·off. Load bytes are latched from `mem_rdata_i`. If off+size ≤ 4, go RESP; otherwise go ACC1.
- ACC1: `mem_addr_o` = word+1, modulo 2^ADDRW, so the last word wraps to 0. The mask covers the remaining low bytes, `(1<<(off+size-4))-1`. `mem_wdata_o` = wdata >> 8·(4-off). Latch the remaining load bytes, then go RESP.
- RESP: `rsp_valid_o`=1 and outputs are held stable until `rsp_ready_i`, then go IDLE. No new request is accepted while not in IDLE.
- Load result: the assembled little-endian value. B and H sign-extend bit 7 or 15; BU and HU zero-extend.
- Memory outputs are all 0 outside ACC0/ACC1, with `cs`=0.

## Timing
- Reset values: `req_ready_o`=1 and all other outputs 0. Reset mid-transaction aborts it to IDLE; a store already issued in ACC0 is not undone.
- Aligned or in-word access: handshake at edge E0, ACC0 during cycle E0→E1, `rsp_valid_o` high from E1. Latency is 2 cycles from handshake to response.
- Split access: one extra cycle, so `rsp_valid_o` rises at E2.
- Error response: `rsp_valid_o` high the cycle after handshake, with no memory cycle.
- Store writes take effect at the edge ending ACC0/ACC1.
- Throughput: at most one request per 3 cycles (2 cycles + RESP) when `rsp_ready_i` is held high.

## Configuration
- `LSU_MISALIGNED_EN` defined: misaligned accesses are supported.
  - H at off 1 is a single access with mask 0110.
  - H at off 3, and W at off 1–3, split into two accesses.
- Not defined: any access with addr not a multiple of size raises `rsp_err_o`=1, does no memory access, and returns rdata 0. ACC1 is unreachable and may be removed.

## Test plan
- SW 0xDEADBEEF to addr 0x10, then LW 0x10. Required: mask 1111, word addr 4, rsp 0xDEADBEEF, 2-cycle latency.
- SB 0x80 to addr 0x13, then LB and LBU at 0x13. Required: mask 1000, wdata 0x80000000; LB returns 0xFFFFFF80 and LBU returns 0x00000080.
- SH 0xA5A5 to addr 0x22, then LHU. Required: mask 1100, returns 0x0000A5A5; LH at the same addr with 0x8001 stored returns 0xFFFF8001.
- With the feature on, SW 0x11223344 to addr 0x0D. Required: ACC0 word 3 mask 1110 wdata 0x22334400; ACC1 word 4 mask 0001 wdata 0x00000011. LW 0x0D returns 0x11223344 at E2. LW at addr 0x3FF (last word, off 3) wraps ACC1 to word 0.
- With the feature off, LW at 0x0D and funct3=011. Required: `rsp_err_o`=1, `mem_cs_o` never asserted, rdata 0.
- Hold `rsp_ready_i`=0 for 5 cycles in RESP. Required: outputs stable and `req_ready_o`=0. Then assert `rst_i` during ACC0 of a new load. Required: all outputs return to their reset values immediately.
